// File: rtl/kernel_pixel_streamer_if.sv
// Pixel/result bus between the kernel pixel streamer and its frame RAM, kernel bank and result RAM.
// The streamer is the master; the surrounding memories and kernels form the slave side.
interface kernel_pixel_streamer_if #(
    parameter int unsigned bitSize    = 6,
    parameter int unsigned pixelWidth = 8
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [bitSize:0]      mem_addr;
    logic [pixelWidth-1:0] mem_rdata;
    logic                  we;
    logic [bitSize:0]      pixel_position_or_address;
    logic [pixelWidth-1:0] data_in;
    logic [pixelWidth-1:0] result_in;
    logic                  wb_we;
    logic [bitSize:0]      wb_addr;
    logic [pixelWidth-1:0] wb_data;

    modport master (
        input  start, mem_rdata, result_in,
        output busy, done, mem_addr, we, pixel_position_or_address, data_in,
               wb_we, wb_addr, wb_data
    );

    modport slave (
        output start, mem_rdata, result_in,
        input  busy, done, mem_addr, we, pixel_position_or_address, data_in,
               wb_we, wb_addr, wb_data
    );
endinterface

// File: rtl/kernel_pixel_streamer.sv
// Streams an N*N frame into the kernel bank (LOAD), then sweeps it again to collect results
// (READOUT); every beat lasts two clocks to suit the kernels' alternate-cycle sampling.
module kernel_pixel_streamer #(
    parameter int unsigned N          = 8,
    parameter int unsigned bitSize    = 6,
    parameter int unsigned pixelWidth = 8
) (
    input logic                     clk,
    input logic                     rst,
    kernel_pixel_streamer_if.master bus
);
    localparam int unsigned AW = bitSize + 1;
    localparam logic [AW-1:0] Last = AW'(N * N - 1);

    typedef enum logic [2:0] {StIdle, StPrime, StLoad, StReadout, StDone} state_e;

    state_e        state;
    logic          phase;
    logic [AW-1:0] k;

    // data_in doubles as the prefetch register: it is loaded with the next pixel at each beat end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                         <= StIdle;
            phase                         <= 1'b0;
            k                             <= '0;
            bus.busy                      <= 1'b0;
            bus.done                      <= 1'b0;
            bus.we                        <= 1'b0;
            bus.wb_we                     <= 1'b0;
            bus.mem_addr                  <= '0;
            bus.pixel_position_or_address <= '0;
            bus.data_in                   <= '0;
            bus.wb_addr                   <= '0;
            bus.wb_data                   <= '0;
        end else begin
            bus.done  <= 1'b0;
            bus.wb_we <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        state        <= StPrime;
                        bus.busy     <= 1'b1;
                        bus.mem_addr <= '0;
                    end
                end
                StPrime: begin
                    state                         <= StLoad;
                    k                             <= '0;
                    phase                         <= 1'b0;
                    bus.we                        <= 1'b1;
                    bus.pixel_position_or_address <= '0;
                    bus.data_in                   <= bus.mem_rdata;
                    bus.mem_addr                  <= AW'(1);
                end
                StLoad: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (k == Last) begin
                            state                         <= StReadout;
                            k                             <= '0;
                            bus.we                        <= 1'b0;
                            bus.pixel_position_or_address <= '0;
                            bus.data_in                   <= '0;
                            bus.mem_addr                  <= '0;
                        end else begin
                            k                             <= k + AW'(1);
                            bus.pixel_position_or_address <= k + AW'(1);
                            bus.data_in                   <= bus.mem_rdata;
                            bus.mem_addr                  <= k + AW'(2);
                        end
                    end
                end
                StReadout: begin
                    if (!phase) begin
                        // Result is stable for the whole beat, so the strobe lands in cycle B.
                        phase       <= 1'b1;
                        bus.wb_we   <= 1'b1;
                        bus.wb_addr <= k;
                        bus.wb_data <= bus.result_in;
                    end else begin
                        phase <= 1'b0;
                        if (k == Last) begin
                            state                         <= StDone;
                            k                             <= '0;
                            bus.busy                      <= 1'b0;
                            bus.done                      <= 1'b1;
                            bus.pixel_position_or_address <= '0;
                        end else begin
                            k                             <= k + AW'(1);
                            bus.pixel_position_or_address <= k + AW'(1);
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_kernel_pixel_streamer.sv
// Self-checking bench: random frames and results, cycle-by-cycle expectations derived from
// the pass timeline (PRIME, two-clock LOAD beats, two-clock READOUT beats, DONE).
module tb_kernel_pixel_streamer;
    localparam int N = 8;
    localparam int NN = N * N;
    localparam int LoadEnd = 1 + 2 * NN;
    localparam int ReadEnd = 1 + 4 * NN;
    localparam int DoneT = ReadEnd + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    kernel_pixel_streamer_if #(.bitSize(6), .pixelWidth(8)) bus ();

    kernel_pixel_streamer #(.N(N), .bitSize(6), .pixelWidth(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] ram     [128];
    logic [7:0] res_tab [128];
    logic [7:0] rdata_q;
    int         cur_t = 0;
    bit         glitch_en = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    // Frame RAM with one clock of read latency; optionally scrambled during LOAD cycle A.
    always @(posedge clk) rdata_q <= ram[bus.mem_addr];
    assign bus.mem_rdata = (glitch_en && cur_t >= 2 && cur_t <= LoadEnd && cur_t % 2 == 0)
                           ? ~rdata_q : rdata_q;
    assign bus.result_in = res_tab[bus.pixel_position_or_address];

    task automatic check(input string tag, input int t, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // {busy, done, we, wb_we, address[6:0], data_in[7:0]} expected at pass cycle t.
    function automatic logic [31:0] exp_ctrl(input int t);
        int k;
        if (t == 1) return {13'd0, 4'b1000, 7'd0, 8'd0};
        if (t >= 2 && t <= LoadEnd) begin
            k = (t - 2) / 2;
            return {13'd0, 4'b1010, 7'(k), ram[k]};
        end
        if (t > LoadEnd && t <= ReadEnd) begin
            k = (t - LoadEnd - 1) / 2;
            return {13'd0, 3'b100, 1'((t - LoadEnd - 1) % 2), 7'(k), 8'd0};
        end
        if (t == DoneT) return {13'd0, 4'b0100, 7'd0, 8'd0};
        return 32'd0;
    endfunction

    function automatic logic [31:0] obs_ctrl();
        return {13'd0, bus.busy, bus.done, bus.we, bus.wb_we, bus.pixel_position_or_address,
                bus.data_in};
    endfunction

    function automatic logic [31:0] obs_all();
        return {bus.busy, bus.done, bus.we, bus.wb_we, bus.mem_addr,
                bus.pixel_position_or_address, bus.wb_addr} | {bus.data_in, bus.wb_data, 16'd0};
    endfunction

    task automatic run_pass(input bit hold_start, input int abort_at);
        int k;
        int strobes = 0;
        @(negedge clk);
        bus.start = 1'b1;
        cur_t = 0;
        for (int t = 1; t <= DoneT; t++) begin
            @(negedge clk);
            cur_t = t;
            if (!hold_start) bus.start = 1'b0;
            check("ctrl", t, obs_ctrl(), exp_ctrl(t));
            if (t >= 1 && t <= LoadEnd) begin
                k = (t <= 1) ? 0 : (t - 2) / 2 + 1;
                if (k < NN) check("mem_addr", t, 32'(bus.mem_addr), 32'(k));
            end
            if (bus.wb_we) strobes++;
            if (t > LoadEnd && t <= ReadEnd && (t - LoadEnd - 1) % 2 == 1) begin
                k = (t - LoadEnd - 1) / 2;
                check("wb_addr", t, 32'(bus.wb_addr), 32'(k));
                check("wb_data", t, 32'(bus.wb_data), 32'(res_tab[k]));
            end
            if (t == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_zero", t, obs_all(), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("abort_idle", t + i, {30'd0, bus.busy, bus.done}, 32'd0);
                end
                return;
            end
        end
        check("wb_count", DoneT, 32'(strobes), 32'(NN));
        if (hold_start) begin
            @(negedge clk);
            check("hold_idle", DoneT + 1, obs_ctrl(), 32'd0);
            @(negedge clk);
            check("hold_restart", DoneT + 2, obs_ctrl(), {13'd0, 4'b1000, 7'd0, 8'd0});
            bus.start = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        @(negedge clk);
        check("post_idle", DoneT + 1, obs_ctrl(), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        for (int i = 0; i < 128; i++) begin
            ram[i]     = 8'(i + 1);
            res_tab[i] = 8'hA0 + 8'(i & 15);
        end
        rst = 1'b1;
        #12;
        check("reset_zero", 0, obs_all(), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge clk);
        check("idle_zero", 20, obs_all(), 32'd0);

        run_pass(1'b0, 0);

        for (int i = 0; i < 128; i++) begin
            ram[i]     = 8'($urandom);
            res_tab[i] = 8'($urandom);
        end
        glitch_en = 1'b1;
        run_pass(1'b0, 0);

        glitch_en = 1'b0;
        run_pass(1'b1, 0);

        for (int i = 0; i < 128; i++) ram[i] = 8'($urandom);
        run_pass(1'b0, 70);
        run_pass(1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
